load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Memory-access stage between the ALU/execute stage and the 256-word data memory.
//  Takes one load/store request per handshake and converts the byte address to a word index.
//  Sub-word stores are done as read-modify-write, because the memory has no byte enables.
//  Loads are aligned and sign/zero-extended; the result goes to writeback over a valid/ready handshake.
// PARAMETERS
//  ADDR_WORDS  256  number of 32-bit words in the data memory; word index >= ADDR_WORDS is an error
// PORTS
//  clk           in   1   system clock, all state updates on posedge
//  reset         in   1   asynchronous, active-high reset
//  req_valid     in   1   execute stage presents a request
//  req_ready     out  1   unit can accept a request (high only in IDLE)
//  req_store     in   1   1 = store, 0 = load
//  req_size      in   2   00 byte, 01 halfword, 10 word, 11 illegal
//  req_unsigned  in   1   load zero-extends when 1, sign-extends when 0
//  req_addr      in   32  byte address from ALU
//  req_wdata     in   32  store data from register file (LSBs used for sub-word)
//  mem_addr      out  32  word index to memory = req_addr[31:2]
//  mem_we        out  1   memory write enable, one-cycle pulse
//  mem_wdata     out  32  word written to memory
//  mem_rdata     in   32  memory read data, valid the cycle after mem_addr is sampled
//  resp_valid    out  1   response available to writeback
//  resp_ready    in   1   writeback accepts response
//  resp_data     out  32  extended load data; 0 for stores and errors
//  resp_err      out  1   misaligned, illegal-size or out-of-range access
// BEHAVIOUR
//  Reset (async): state=IDLE; req_ready=1; mem_we=0; mem_addr=0; mem_wdata=0;
//    resp_valid=0; resp_data=0; resp_err=0. All request capture registers are cleared.
//  All outputs are registered except req_ready, which is (state==IDLE).
//  States: IDLE, RD, RWAIT, WR, RESP.
//  IDLE, when req_valid&&req_ready: capture the request. Then:
//    error (half with addr[0]; word with addr[1:0]!=0; size 11; addr[31:2]>=ADDR_WORDS)
//      -> RESP with resp_err=1 and resp_data=0; no memory access.
//    word store -> WR with mem_we=1, mem_wdata=req_wdata, mem_addr=index.
//    load, or byte/half store -> RD with mem_addr=index and mem_we=0.
//  RD: memory samples the address -> RWAIT.
//  RWAIT: mem_rdata is valid. Then:
//    load -> RESP; resp_data = lane selected by addr[1:0] (byte) or addr[1] (half), extended.
//    sub-word store -> WR; mem_wdata = mem_rdata with the lane replaced by req_wdata[7:0] or [15:0].
//  WR: mem_we high for exactly this cycle -> RESP; mem_we returns to 0.
//  RESP: hold resp_valid=1 and keep resp_data/resp_err stable until resp_ready.
//    On the handshake edge -> IDLE and resp_valid=0. No new request is accepted in RESP.
//  Latency, accept edge to resp_valid: error 1, word store 2, load 3, sub-word store 4.
//  Byte lanes are little-endian: addr[1:0]=0 is bits [7:0]; half addr[1]=1 is bits [31:16].
//  mem_we is never high outside WR, and never high for more than one cycle per request.
//  Reset mid-operation: abandon the request. A read-modify-write aborted before WR writes nothing.
//  Reset asserted during WR drops mem_we immediately.
//  req_* inputs are ignored outside IDLE; a changing req_addr mid-operation has no effect.
// TESTING
//  Word store addr 0x10, data 0xDEADBEEF -> mem_we pulse at index 4 with 0xDEADBEEF; resp 2 cycles later, err=0.
//  Load byte signed, addr 0x13, mem[4]=0x80FF1234 -> resp_data=0xFFFFFF80.
//  Same location, unsigned half addr 0x12 -> resp_data=0x000080FF.
//  Store byte 0xAB to addr 0x11, mem[4]=0x11223344 -> RD, RWAIT, WR writes 0x1122AB44; resp at cycle 4.
//  Errors: half load at 0x21, word load at 0x400 (index 256), size 11 -> err=1, data=0, no mem_we, latency 1.
//  Backpressure and reset:
//    resp_ready low 5 cycles -> resp held stable and req_ready=0.
//    Reset in RWAIT of a byte store -> IDLE, memory unchanged.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Bus bundle for the load/store unit.
//   Request side  : req_valid/req_ready handshake with store flag, access size,
//                   unsigned flag, byte address and store data.
//   Memory side   : word index, one-cycle write enable, write data, read data
//                   (read data valid the cycle after the index is sampled).
//   Response side : resp_valid/resp_ready handshake with extended load data and
//                   an error flag.
// The unit itself connects through the slave modport; the environment (execute
// stage, memory, writeback, or a testbench) uses the master modport.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        resp_err;

  modport slave (
    input  req_valid, req_store, req_size, req_unsigned, req_addr, req_wdata,
    input  mem_rdata, resp_ready,
    output req_ready, mem_addr, mem_we, mem_wdata,
    output resp_valid, resp_data, resp_err
  );

  modport master (
    output req_valid, req_store, req_size, req_unsigned, req_addr, req_wdata,
    output mem_rdata, resp_ready,
    input  req_ready, mem_addr, mem_we, mem_wdata,
    input  resp_valid, resp_data, resp_err
  );
endinterface

// File: rtl/load_store_unit.sv
// Memory-access stage between execute and a word-addressed data memory.
// Accepts one load/store per request handshake, converts the byte address to a
// word index, performs sub-word stores as read-modify-write (the memory has no
// byte enables), aligns and extends load data, and returns a response over a
// valid/ready handshake.
// Ports:
//   clk    : system clock, all state updates on posedge
//   reset  : asynchronous, active-high reset
//   bus    : load_store_unit_if.slave (request, memory and response signals)
// All bus outputs are registered except req_ready, which is high only in IDLE.
module load_store_unit #(
  parameter int ADDR_WORDS = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  load_store_unit_if.slave      bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_RWAIT,
    S_WR,
    S_RESP
  } state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  state_e      state_q, state_d;
  logic        store_q, store_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [1:0]  lane_q, lane_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_data_q, resp_data_d;
  logic        resp_err_q, resp_err_d;

  logic        req_err;

  // Select the addressed lane of a memory word and sign/zero-extend it.
  function automatic logic [31:0] extend_load(input logic [31:0] word,
                                              input logic [1:0]  size,
                                              input logic [1:0]  lane,
                                              input logic        is_uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: r = is_uns ? {24'h0, b} : {{24{b[7]}}, b};
      SZ_HALF: r = is_uns ? {16'h0, h} : {{16{h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Replace the addressed lane of the old memory word with the store data LSBs.
  function automatic logic [31:0] merge_store(input logic [31:0] old_word,
                                              input logic [31:0] st_data,
                                              input logic [1:0]  size,
                                              input logic [1:0]  lane);
    logic [31:0] r;
    r = old_word;
    case (size)
      SZ_BYTE: r[{lane, 3'b000} +: 8] = st_data[7:0];
      SZ_HALF: begin
        if (lane[1]) r[31:16] = st_data[15:0];
        else         r[15:0]  = st_data[15:0];
      end
      default: r = st_data;
    endcase
    return r;
  endfunction

  // Misaligned, illegal size, or word index beyond the memory.
  always_comb begin
    req_err = 1'b0;
    case (bus.req_size)
      SZ_HALF: req_err = bus.req_addr[0];
      SZ_WORD: req_err = (bus.req_addr[1:0] != 2'b00);
      SZ_BYTE: req_err = 1'b0;
      default: req_err = 1'b1;
    endcase
    if ({2'b00, bus.req_addr[31:2]} >= 32'(ADDR_WORDS)) req_err = 1'b1;
  end

  // NOTE: every signal driven here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    store_d      = store_q;
    size_d       = size_q;
    uns_d        = uns_q;
    lane_d       = lane_q;
    wdata_d      = wdata_q;
    mem_addr_d   = mem_addr_q;
    mem_we_d     = 1'b0;
    mem_wdata_d  = mem_wdata_q;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    resp_err_d   = resp_err_q;

    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          store_d = bus.req_store;
          size_d  = bus.req_size;
          uns_d   = bus.req_unsigned;
          lane_d  = bus.req_addr[1:0];
          wdata_d = bus.req_wdata;
          if (req_err) begin
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_data_d  = 32'h0;
            state_d      = S_RESP;
          end else if (bus.req_store && bus.req_size == SZ_WORD) begin
            mem_addr_d  = {2'b00, bus.req_addr[31:2]};
            mem_wdata_d = bus.req_wdata;
            mem_we_d    = 1'b1;
            state_d     = S_WR;
          end else begin
            mem_addr_d = {2'b00, bus.req_addr[31:2]};
            state_d    = S_RD;
          end
        end
      end
      S_RD: state_d = S_RWAIT;
      S_RWAIT: begin
        if (store_q) begin
          mem_wdata_d = merge_store(bus.mem_rdata, wdata_q, size_q, lane_q);
          mem_we_d    = 1'b1;
          state_d     = S_WR;
        end else begin
          resp_data_d  = extend_load(bus.mem_rdata, size_q, lane_q, uns_q);
          resp_err_d   = 1'b0;
          resp_valid_d = 1'b1;
          state_d      = S_RESP;
        end
      end
      S_WR: begin
        resp_data_d  = 32'h0;
        resp_err_d   = 1'b0;
        resp_valid_d = 1'b1;
        state_d      = S_RESP;
      end
      S_RESP: begin
        if (bus.resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge value, independent of statement order.
  // NOTE: reset clears every register, including the captured request, so an
  // aborted read-modify-write leaves nothing pending and mem_we drops at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      store_q      <= 1'b0;
      size_q       <= 2'b00;
      uns_q        <= 1'b0;
      lane_q       <= 2'b00;
      wdata_q      <= 32'h0;
      mem_addr_q   <= 32'h0;
      mem_we_q     <= 1'b0;
      mem_wdata_q  <= 32'h0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= 32'h0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      store_q      <= store_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      lane_q       <= lane_d;
      wdata_q      <= wdata_d;
      mem_addr_q   <= mem_addr_d;
      mem_we_q     <= mem_we_d;
      mem_wdata_q  <= mem_wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign bus.req_ready  = (state_q == S_IDLE);
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_err   = resp_err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: a table of single requests with
// expected response, latency and memory effect, plus hand-written sequences
// for response backpressure and reset in the middle of an access.
module tb_load_store_unit;

  logic clk;
  logic reset;

  load_store_unit_if bus ();

  load_store_unit #(.ADDR_WORDS(256)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory model: synchronous read, read data valid the cycle after the
  // index is sampled. A backdoor port lets the bench preload words.
  logic [31:0] mem [256];
  logic        bd_we;
  logic [7:0]  bd_idx;
  logic [31:0] bd_data;
  int          wr_count;
  logic [31:0] last_wr_idx;
  logic [31:0] last_wr_data;

  always @(posedge clk) begin
    bus.mem_rdata <= mem[bus.mem_addr[7:0]];
    if (bd_we) begin
      mem[bd_idx] <= bd_data;
    end else if (bus.mem_we) begin
      mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
      wr_count     <= wr_count + 1;
      last_wr_idx  <= bus.mem_addr;
      last_wr_data <= bus.mem_wdata;
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        store;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] pre;
    logic [31:0] exp_data;
    logic        exp_err;
    int          exp_lat;
    logic        exp_we;
    logic [31:0] exp_mem;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          lat;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];

  task automatic bd_write(input logic [7:0] idx, input logic [31:0] data);
    @(negedge clk);
    bd_we = 1'b1; bd_idx = idx; bd_data = data;
    @(posedge clk); #1;
    bd_we = 1'b0;
  endtask

  // Present a request; returns #1 after the accept edge with req_* scrambled
  // so that any late sampling of the inputs would show up.
  task automatic drive_req(input logic st, input logic [1:0] sz, input logic un,
                           input logic [31:0] ad, input logic [31:0] wd);
    @(negedge clk);
    check("req_ready_before_req", 32'(bus.req_ready), 32'd1);
    bus.req_store = st; bus.req_size = sz; bus.req_unsigned = un;
    bus.req_addr = ad; bus.req_wdata = wd; bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid    = 1'b0;
    bus.req_addr     = $urandom;
    bus.req_wdata    = $urandom;
    bus.req_size     = 2'($urandom_range(0, 3));
    bus.req_store    = 1'($urandom_range(0, 1));
    bus.req_unsigned = 1'($urandom_range(0, 1));
  endtask

  // Latency counts the accept edge as 1.
  task automatic wait_resp(output int lat);
    lat = 1;
    while (!bus.resp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!bus.resp_valid) check("resp_timeout", 32'(bus.resp_valid), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int          lat;
    int          wr0;
    exp_t        e;
    logic [31:0] held;
    logic        in_range;

    bus.req_valid = 0; bus.req_store = 0; bus.req_size = 0; bus.req_unsigned = 0;
    bus.req_addr = 0; bus.req_wdata = 0; bus.resp_ready = 1;
    bd_we = 0; bd_idx = 0; bd_data = 0;
    wr_count = 0; last_wr_idx = 0; last_wr_data = 0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;

    //           st    sz     un    addr          wdata         pre           exp_data      err  lat we  exp_mem
    vecs.push_back('{1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 32'h0000_0000, 1'b0, 2, 1'b1, 32'hDEAD_BEEF});
    vecs.push_back('{1'b0, 2'b00, 1'b0, 32'h0000_0013, 32'h0,         32'h80FF_1234, 32'hFFFF_FF80, 1'b0, 3, 1'b0, 32'h80FF_1234});
    vecs.push_back('{1'b0, 2'b01, 1'b1, 32'h0000_0012, 32'h0,         32'h80FF_1234, 32'h0000_80FF, 1'b0, 3, 1'b0, 32'h80FF_1234});
    vecs.push_back('{1'b0, 2'b00, 1'b1, 32'h0000_0012, 32'h0,         32'h80FF_1234, 32'h0000_00FF, 1'b0, 3, 1'b0, 32'h80FF_1234});
    vecs.push_back('{1'b0, 2'b00, 1'b0, 32'h0000_0010, 32'h0,         32'h80FF_1234, 32'h0000_0034, 1'b0, 3, 1'b0, 32'h80FF_1234});
    vecs.push_back('{1'b0, 2'b01, 1'b0, 32'h0000_0012, 32'h0,         32'h80FF_1234, 32'hFFFF_80FF, 1'b0, 3, 1'b0, 32'h80FF_1234});
    vecs.push_back('{1'b0, 2'b01, 1'b0, 32'h0000_0010, 32'h0,         32'h80FF_1234, 32'h0000_1234, 1'b0, 3, 1'b0, 32'h80FF_1234});
    vecs.push_back('{1'b0, 2'b10, 1'b0, 32'h0000_0020, 32'h0,         32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, 3, 1'b0, 32'hCAFE_F00D});
    vecs.push_back('{1'b1, 2'b00, 1'b0, 32'h0000_0011, 32'hFFFF_FFAB, 32'h1122_3344, 32'h0000_0000, 1'b0, 4, 1'b1, 32'h1122_AB44});
    vecs.push_back('{1'b1, 2'b00, 1'b0, 32'h0000_0013, 32'h0000_00CD, 32'h1122_3344, 32'h0000_0000, 1'b0, 4, 1'b1, 32'hCD22_3344});
    vecs.push_back('{1'b1, 2'b00, 1'b0, 32'h0000_0010, 32'h0000_0077, 32'h1122_3344, 32'h0000_0000, 1'b0, 4, 1'b1, 32'h1122_3377});
    vecs.push_back('{1'b1, 2'b00, 1'b1, 32'h0000_0012, 32'h0055_00EE, 32'h1122_3344, 32'h0000_0000, 1'b0, 4, 1'b1, 32'h11EE_3344});
    vecs.push_back('{1'b1, 2'b01, 1'b0, 32'h0000_002A, 32'h1234_BEEF, 32'h1122_3344, 32'h0000_0000, 1'b0, 4, 1'b1, 32'hBEEF_3344});
    vecs.push_back('{1'b1, 2'b01, 1'b0, 32'h0000_0028, 32'hFFFF_5678, 32'hAABB_CCDD, 32'h0000_0000, 1'b0, 4, 1'b1, 32'hAABB_5678});
    vecs.push_back('{1'b0, 2'b10, 1'b0, 32'h0000_03FC, 32'h0,         32'h5A5A_0001, 32'h5A5A_0001, 1'b0, 3, 1'b0, 32'h5A5A_0001});
    vecs.push_back('{1'b0, 2'b01, 1'b0, 32'h0000_0021, 32'h0,         32'h1234_5678, 32'h0000_0000, 1'b1, 1, 1'b0, 32'h1234_5678});
    vecs.push_back('{1'b0, 2'b10, 1'b0, 32'h0000_0400, 32'h0,         32'h0,         32'h0000_0000, 1'b1, 1, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 2'b11, 1'b0, 32'h0000_0020, 32'h0,         32'h0BAD_F00D, 32'h0000_0000, 1'b1, 1, 1'b0, 32'h0BAD_F00D});
    vecs.push_back('{1'b1, 2'b10, 1'b0, 32'h0000_0012, 32'hFFFF_FFFF, 32'h0F0F_0F0F, 32'h0000_0000, 1'b1, 1, 1'b0, 32'h0F0F_0F0F});
    vecs.push_back('{1'b1, 2'b00, 1'b0, 32'h0000_0400, 32'h0000_00AA, 32'h0,         32'h0000_0000, 1'b1, 1, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 2'b01, 1'b0, 32'h0000_0023, 32'h0000_9999, 32'h7777_7777, 32'h0000_0000, 1'b1, 1, 1'b0, 32'h7777_7777});
    vecs.push_back('{1'b0, 2'b00, 1'b0, 32'hFFFF_FFFC, 32'h0,         32'h0,         32'h0000_0000, 1'b1, 1, 1'b0, 32'h0});

    // Reset state
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready",  32'(bus.req_ready),  32'd1);
    check("rst_mem_we",     32'(bus.mem_we),     32'd0);
    check("rst_mem_addr",   bus.mem_addr,        32'h0);
    check("rst_mem_wdata",  bus.mem_wdata,       32'h0);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_resp_data",  bus.resp_data,       32'h0);
    check("rst_resp_err",   32'(bus.resp_err),   32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Table-driven single requests
    foreach (vecs[i]) begin
      vec_t v;
      v = vecs[i];
      in_range = (v.addr[31:10] == 22'h0);
      if (in_range) bd_write(v.addr[9:2], v.pre);
      wr0 = wr_count;
      exp_q.push_back('{v.exp_data, v.exp_err, v.exp_lat});
      drive_req(v.store, v.size, v.uns, v.addr, v.wdata);
      wait_resp(lat);
      e = exp_q.pop_front();
      check($sformatf("v%0d_resp_data", i), bus.resp_data, e.data);
      check($sformatf("v%0d_resp_err", i), 32'(bus.resp_err), 32'(e.err));
      check($sformatf("v%0d_latency", i), 32'(lat), 32'(e.lat));
      check($sformatf("v%0d_req_ready_in_resp", i), 32'(bus.req_ready), 32'd0);
      @(posedge clk); #1;
      check($sformatf("v%0d_resp_valid_after_hs", i), 32'(bus.resp_valid), 32'd0);
      check($sformatf("v%0d_write_count", i), 32'(wr_count - wr0), 32'(v.exp_we));
      if (v.exp_we) begin
        check($sformatf("v%0d_write_index", i), last_wr_idx, {22'h0, v.addr[11:2]});
        check($sformatf("v%0d_write_data", i), last_wr_data, v.exp_mem);
      end
      if (in_range) check($sformatf("v%0d_mem_word", i), mem[v.addr[9:2]], v.exp_mem);
    end

    // Backpressure: response held stable for 5 cycles, no new request taken.
    bd_write(8'd9, 32'h1357_9BDF);
    bus.resp_ready = 1'b0;
    wr0 = wr_count;
    exp_q.push_back('{32'h1357_9BDF, 1'b0, 3});
    drive_req(1'b0, 2'b10, 1'b0, 32'h0000_0024, 32'h0);
    wait_resp(lat);
    e = exp_q.pop_front();
    check("bp_resp_data", bus.resp_data, e.data);
    check("bp_latency", 32'(lat), 32'(e.lat));
    held = bus.resp_data;
    bus.req_valid = 1'b1; bus.req_store = 1'b1; bus.req_size = 2'b10;
    bus.req_addr = 32'h0000_0024; bus.req_wdata = 32'h0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check($sformatf("bp_hold%0d_valid", c), 32'(bus.resp_valid), 32'd1);
      check($sformatf("bp_hold%0d_data", c), bus.resp_data, held);
      check($sformatf("bp_hold%0d_err", c), 32'(bus.resp_err), 32'd0);
      check($sformatf("bp_hold%0d_req_ready", c), 32'(bus.req_ready), 32'd0);
    end
    bus.req_valid = 1'b0;
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_valid", 32'(bus.resp_valid), 32'd0);
    check("bp_release_req_ready", 32'(bus.req_ready), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("bp_no_write", 32'(wr_count - wr0), 32'd0);
    check("bp_mem_word", mem[9], 32'h1357_9BDF);

    // Reset during RWAIT of a byte store: memory must be untouched.
    bd_write(8'd5, 32'h1122_3344);
    wr0 = wr_count;
    drive_req(1'b1, 2'b00, 1'b0, 32'h0000_0014, 32'h0000_00AB);
    @(posedge clk); #1;
    check("rwait_mem_addr", bus.mem_addr, 32'd5);
    reset = 1'b1;
    #1;
    check("rwait_rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rwait_rst_mem_we", 32'(bus.mem_we), 32'd0);
    check("rwait_rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("rwait_rst_no_write", 32'(wr_count - wr0), 32'd0);
    check("rwait_rst_mem_word", mem[5], 32'h1122_3344);
    check("rwait_rst_resp_idle", 32'(bus.resp_valid), 32'd0);

    // Reset during WR drops mem_we immediately.
    bd_write(8'd6, 32'h0102_0304);
    wr0 = wr_count;
    drive_req(1'b1, 2'b10, 1'b0, 32'h0000_0018, 32'hFFFF_0000);
    check("wr_mem_we_high", 32'(bus.mem_we), 32'd1);
    reset = 1'b1;
    #1;
    check("wr_rst_mem_we_low", 32'(bus.mem_we), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("wr_rst_no_write", 32'(wr_count - wr0), 32'd0);
    check("wr_rst_mem_word", mem[6], 32'h0102_0304);

    // Unit still works after the aborted accesses.
    wr0 = wr_count;
    exp_q.push_back('{32'h0000_0011, 1'b0, 3});
    drive_req(1'b0, 2'b00, 1'b1, 32'h0000_0017, 32'h0);
    wait_resp(lat);
    e = exp_q.pop_front();
    check("post_rst_resp_data", bus.resp_data, e.data);
    check("post_rst_latency", 32'(lat), 32'(e.lat));
    @(posedge clk); #1;
    check("post_rst_no_write", 32'(wr_count - wr0), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
